cp0_regfile: RTL
================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter CP0_CONFIG0_INIT, default 32'h8000_0000, meaning Config0 reset and constant value.
REQ-002 SHALL have parameter CP0_STATUS_INIT, default 32'h0040_0000, meaning Status reset value (BEV=1).
REQ-003 SHALL have ports (clock and reset ports per codebase naming; one clock; reset asynchronous, active-high):
 clk  in  1  sole clock
 rst  in  1  asynchronous active-high reset
 hw_int  in  6  external interrupt lines, level
 write_en  in  1  MTC0 commit from WB
 write_addr  in  5  CP0 register number
 write_data  in  32  MTC0 data
 read_addr  in  5  MFC0 register number
 exc_valid  in  1  exception commit, one-cycle pulse
 exc_code  in  5  Cause.ExcCode value
 exc_pc  in  32  faulting PC
 exc_bd  in  1  fault in delay slot
 exc_badvaddr  in  32  bad address for AdEL/AdES (codes 4/5)
 eret  in  1  ERET commit, one-cycle pulse
 read_data  out  32  combinational read of read_addr, 0 for unimplemented
 count_o, status_o, cause_o, epc_o, config0_o  out  32 each  current register values
 int_req  out  1  interrupt pending and enabled
 timer_int  out  1  Cause.IP7 mirror

Function
REQ-004 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), Config0(16).
REQ-005 SHALL increment Count every second clock via internal tick toggle; wraps 32'hFFFF_FFFF -> 0.
REQ-006 SHALL let MTC0 to Count override the increment in that cycle and clear the tick.
REQ-007 SHALL set Cause[15] (IP7/TI) at the edge where Count == Compare, unless Compare is written that cycle.
REQ-008 SHALL clear Cause[15] on any MTC0 to Compare; TI otherwise sticky.
REQ-009 SHALL sample hw_int[4:0] into Cause[14:10] every cycle; Cause[15] = TI OR hw_int[5].
REQ-010 SHALL let MTC0 modify only Status[15:8], Status[1], Status[0] and Cause[9:8]; other bits hold; Config0 read-only.
REQ-011 SHALL on exc_valid: Cause[6:2]=exc_code; if Status.EXL=0, EPC=exc_bd ? exc_pc-4 : exc_pc and Cause[31]=exc_bd; Status.EXL=1; BadVAddr=exc_badvaddr when exc_code is 4 or 5.
REQ-012 SHALL on eret (without exc_valid) clear Status.EXL.
REQ-013 SHALL give priority exc_valid > eret > write_en for overlapping fields in one cycle.
REQ-014 SHALL update all registers on the clock edge; outputs reflect new values the next cycle (1-cycle latency); no internal bypass.
REQ-015 SHALL drive int_req = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational from registers.
REQ-016 SHALL return 0 on read_data for unimplemented addresses; ignore writes to them.

Reset
REQ-017 SHALL asynchronously on rst set Count=0, Compare=0, Cause=0, EPC=0, BadVAddr=0, tick=0, Status=CP0_STATUS_INIT, Config0=CP0_CONFIG0_INIT; int_req=0, timer_int=0.
REQ-018 SHALL cancel pending increment, TI and any in-flight exception effect when rst asserts mid-operation.

Structure
REQ-019 SHALL take register numbers, field bit positions and ExcCode constants from the shared cp0 include; data width from the bus include.
REQ-020 SHALL contain one sub-module cp0_timer (Count, Compare, tick, TI set/clear).

Verification
REQ-021 Reset, idle 10 cycles -> count_o=5, status_o=32'h0040_0000, int_req=0.
REQ-022 MTC0 Compare=8, Count=0, Status=32'h0000_8001 -> Count reaches 8 after 16 cycles, timer_int=1, int_req=1; MTC0 Compare -> timer_int=0 next cycle.
REQ-023 exc_valid, exc_code=4, exc_pc=32'hBFC0_0100, exc_bd=1, badvaddr=32'h1 -> EPC=32'hBFC0_00FC, Cause[31]=1, Cause[6:2]=4, EXL=1, BadVAddr=1.
REQ-024 Second exception with EXL=1 -> EPC unchanged, ExcCode updated; eret -> EXL=0.
REQ-025 Same cycle exc_valid and MTC0 Status=0 -> EXL=1; IE/IM take written values.
REQ-026 Count=32'hFFFF_FFFF, two ticks -> Count=0; rst pulse mid-count -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: CP0 register numbers, field positions and ExcCode constants.
package cp0_regfile_pkg;
  localparam int DW = 32;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_CONFIG0  = 5'd16;
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 15;
  localparam int CA_EXC_LSB = 2;
  localparam int CA_HW_LSB  = 10;
  localparam logic [DW-1:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [DW-1:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with half-rate increment and sticky timer interrupt.
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          count_we_i,
  input  logic          compare_we_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] count_o,
  output logic [DW-1:0] compare_o,
  output logic          ti_o
);
  logic [DW-1:0] count_q, count_d, compare_q, compare_d;
  logic          tick_q, tick_d, ti_q, ti_d;
  always_comb begin
    tick_d    = count_we_i ? 1'b0 : ~tick_q;
    count_d   = count_we_i ? wdata_i : count_q + {{(DW-1){1'b0}}, tick_q};
    compare_d = compare_we_i ? wdata_i : compare_q;
    ti_d      = compare_we_i ? 1'b0 : (ti_q | (count_q == compare_q));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end
  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC, Config0).
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] CP0_CONFIG0_INIT = 32'h8000_0000,
  parameter logic [31:0] CP0_STATUS_INIT  = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    hw_int,
  input  logic          write_en,
  input  logic [4:0]    write_addr,
  input  logic [DW-1:0] write_data,
  input  logic [4:0]    read_addr,
  input  logic          exc_valid,
  input  logic [4:0]    exc_code,
  input  logic [DW-1:0] exc_pc,
  input  logic          exc_bd,
  input  logic [DW-1:0] exc_badvaddr,
  input  logic          eret,
  output logic [DW-1:0] read_data,
  output logic [DW-1:0] count_o,
  output logic [DW-1:0] status_o,
  output logic [DW-1:0] cause_o,
  output logic [DW-1:0] epc_o,
  output logic [DW-1:0] config0_o,
  output logic          int_req,
  output logic          timer_int
);
  logic [DW-1:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [DW-1:0] compare;
  logic          ti;
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (write_en && write_addr == CP0_COUNT),
    .compare_we_i (write_en && write_addr == CP0_COMPARE),
    .wdata_i      (write_data),
    .count_o      (count_o),
    .compare_o    (compare),
    .ti_o         (ti)
  );
  // cause_q[15] holds only the sampled hw_int[5]; TI is merged in from the timer
  always_comb begin
    status_d   = (write_en && write_addr == CP0_STATUS) ?
                 (status_q & ~STATUS_WMASK) | (write_data & STATUS_WMASK) : status_q;
    cause_d    = (write_en && write_addr == CP0_CAUSE) ?
                 (cause_q & ~CAUSE_WMASK) | (write_data & CAUSE_WMASK) : cause_q;
    cause_d[CA_TI:CA_HW_LSB] = hw_int;
    epc_d      = (write_en && write_addr == CP0_EPC) ? write_data : epc_q;
    badvaddr_d = badvaddr_q;
    if (exc_valid) begin
      cause_d[CA_EXC_LSB+4:CA_EXC_LSB] = exc_code;
      if (!status_q[ST_EXL]) begin
        epc_d        = exc_bd ? exc_pc - 32'd4 : exc_pc;
        cause_d[CA_BD] = exc_bd;
      end
      status_d[ST_EXL] = 1'b1;
      badvaddr_d = (exc_code == EXC_ADEL || exc_code == EXC_ADES) ? exc_badvaddr : badvaddr_q;
    end else if (eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= CP0_STATUS_INIT;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end
  assign status_o  = status_q;
  assign cause_o   = {cause_q[DW-1:CA_TI+1], cause_q[CA_TI] | ti, cause_q[CA_TI-1:0]};
  assign epc_o     = epc_q;
  assign config0_o = CP0_CONFIG0_INIT;
  assign timer_int = cause_o[CA_TI];
  assign int_req   = status_q[ST_IE] & ~status_q[ST_EXL] & |(cause_o[15:8] & status_q[15:8]);
  assign read_data = read_addr == CP0_BADVADDR ? badvaddr_q :
                     read_addr == CP0_COUNT    ? count_o    :
                     read_addr == CP0_COMPARE  ? compare    :
                     read_addr == CP0_STATUS   ? status_o   :
                     read_addr == CP0_CAUSE    ? cause_o    :
                     read_addr == CP0_EPC      ? epc_o      :
                     read_addr == CP0_CONFIG0  ? config0_o  : '0;
endmodule
